// File: rtl/token_stream_tx_if.sv
// token_stream_tx_if: buffer-load and word-stream bundle
// master = controller side, slave = token_stream_tx
interface token_stream_tx_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 5
);
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              start;
  logic [ADDR_W:0]   len;
  logic [1:0]        block_sel_in;
  logic              data_ready;
  logic [DATA_W-1:0] data_in;
  logic              data_in_valid;
  logic [1:0]        block_sel;
  logic              busy;
  logic              done;

  modport master (
    output wr_en, wr_addr, wr_data,
    output start, len, block_sel_in,
    output data_ready,
    input  data_in, data_in_valid,
    input  block_sel, busy, done
  );

  modport slave (
    input  wr_en, wr_addr, wr_data,
    input  start, len, block_sel_in,
    input  data_ready,
    output data_in, data_in_valid,
    output block_sel, busy, done
  );
endinterface

// File: rtl/token_stream_tx.sv
// token_stream_tx: buffers token words, then streams
// buffer[0..len-1] over a valid/ready port
module token_stream_tx #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5
) (
  input logic              clk,
  input logic              rst_n,
  token_stream_tx_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    STREAM,
    DONE
  } state_t;

  localparam logic [ADDR_W:0] DEPTH_L =
    (ADDR_W+1)'(DEPTH);

  state_t state;
  state_t state_nxt;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W:0] ptr;
  logic [ADDR_W:0] ptr_inc;
  logic [ADDR_W:0] len_q;
  logic [ADDR_W:0] len_clamp;
  logic            go;
  logic            xfer;
  logic            last;

  assign go = (state == IDLE) && bus.start &&
              (bus.len != '0);

  assign len_clamp = (bus.len > DEPTH_L) ?
                     DEPTH_L : bus.len;

  assign xfer = (state == STREAM) &&
                bus.data_in_valid &&
                bus.data_ready;

  // ptr is the index of the word now on data_in
  assign ptr_inc = ptr + 1'b1;
  assign last    = (ptr_inc == len_q);

  assign bus.busy = (state != IDLE);
  assign bus.done = (state == DONE);

  // buffer is only writable while idle; never reset
  always_ff @(posedge clk) begin
    if (state == IDLE && bus.wr_en)
      mem[bus.wr_addr] <= bus.wr_data;
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // next-state decode
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:   if (go) state_nxt = LOAD;
      LOAD:   state_nxt = STREAM;
      STREAM: if (xfer && last) state_nxt = DONE;
      DONE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // stream datapath: latch params, load and advance words
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q             <= '0;
      ptr               <= '0;
      bus.block_sel     <= '0;
      bus.data_in       <= '0;
      bus.data_in_valid <= 1'b0;
    end else begin
      if (go) begin
        len_q         <= len_clamp;
        bus.block_sel <= bus.block_sel_in;
        ptr           <= '0;
      end
      if (state == LOAD) begin
        bus.data_in       <= mem[0];
        bus.data_in_valid <= 1'b1;
      end
      if (xfer) begin
        if (last) begin
          bus.data_in_valid <= 1'b0;
        end else begin
          bus.data_in <= mem[ptr_inc[ADDR_W-1:0]];
          ptr         <= ptr_inc;
        end
      end
    end
  end

endmodule

// File: tb/tb_token_stream_tx.sv
// tb_token_stream_tx: table vectors, random streams
// and reset/interlock sequences against a buffer model
module tb_token_stream_tx;

  logic clk;
  logic rst_n;

  token_stream_tx_if #(.DATA_W(16), .ADDR_W(5)) bus ();

  token_stream_tx #(
    .DATA_W(16),
    .DEPTH (32),
    .ADDR_W(5)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_bad;

  logic [15:0] ref_mem [32];

  typedef struct {
    int         ln;
    logic [1:0] bs;
    int         mode;
    bit         poke;
    int         exp_n;
  } vec_t;

  vec_t vecs [$];

  task automatic chk(input string name,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h",
               name, got, exp);
    end
  endtask

  // all tasks start and end at posedge+1
  task automatic write_word(input int a,
                            input logic [15:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_addr = 5'(a);
    bus.wr_data = d;
    ref_mem[a]  = d;
    @(posedge clk); #1;
    bus.wr_en   = 1'b0;
  endtask

  task automatic run_stream(input int ln,
                            input logic [1:0] bs,
                            input int mode,
                            input bit poke,
                            input int exp_n);
    logic [15:0] got [$];
    logic [15:0] prev_d;
    bit   prev_stall;
    int   first_v;
    int   last_x;
    int   done_c;
    int   done_n;
    int   busy_n;
    int   bs_bad;
    int   stab_bad;
    bit   finished;
    bit   rdy;
    first_v    = -1;
    last_x     = -1;
    done_c     = -1;
    done_n     = 0;
    busy_n     = 0;
    bs_bad     = 0;
    stab_bad   = 0;
    finished   = 0;
    prev_stall = 0;
    prev_d     = '0;
    bus.start        = 1'b1;
    bus.len          = 6'(ln);
    bus.block_sel_in = bs;
    bus.data_ready   = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    if (bus.busy) busy_n++;
    for (int c = 0; c < 600; c++) begin
      unique case (mode)
        0: rdy = 1'b1;
        1: rdy = c[0];
        default: rdy = ($urandom_range(0, 3) != 0);
      endcase
      bus.data_ready = rdy;
      if (poke && c == 3) begin
        bus.wr_en        = 1'b1;
        bus.wr_addr      = '0;
        bus.wr_data      = 16'hDEAD;
        bus.start        = 1'b1;
        bus.len          = 6'd5;
        bus.block_sel_in = ~bs;
      end else begin
        bus.wr_en = 1'b0;
        bus.start = 1'b0;
      end
      @(negedge clk);
      if (bus.busy) begin
        busy_n++;
        if (bus.block_sel !== bs) bs_bad++;
      end
      if (bus.done) begin
        done_n++;
        if (done_c < 0) done_c = c;
      end
      if (bus.data_in_valid) begin
        if (first_v < 0) first_v = c;
        if (prev_stall && bus.data_in !== prev_d)
          stab_bad++;
        if (rdy) begin
          got.push_back(bus.data_in);
          last_x = c;
        end
      end
      prev_stall = bus.data_in_valid && !rdy;
      prev_d     = bus.data_in;
      if (exp_n == 0 && c == 5) begin
        finished = 1;
        break;
      end
      if (done_c >= 0 && c == done_c + 1) begin
        finished = 1;
        break;
      end
      @(posedge clk); #1;
    end
    chk("finish", 32'(finished), 32'd1);
    chk("count", got.size(), exp_n);
    for (int i = 0; i < got.size() && i < exp_n; i++)
      chk($sformatf("word%0d", i), got[i], ref_mem[i]);
    chk("stall_stable", stab_bad, 0);
    if (exp_n == 0) begin
      chk("len0_busy", busy_n, 0);
      chk("len0_done", done_n, 0);
    end else begin
      chk("done_once", done_n, 1);
      chk("done_lat", done_c, last_x + 1);
      chk("first_lat", first_v, 1);
      chk("block_sel", bs_bad, 0);
      chk("end_busy", 32'(bus.busy), 0);
      chk("end_valid", 32'(bus.data_in_valid), 0);
      chk("retain", bus.data_in, ref_mem[exp_n-1]);
      chk("bsel_hold", bus.block_sel, bs);
      if (mode == 0)
        chk("thruput", last_x - first_v, exp_n - 1);
    end
    @(posedge clk); #1;
    bus.data_ready = 1'b0;
    bus.wr_en      = 1'b0;
    bus.start      = 1'b0;
  endtask

  task automatic reset_mid_stream();
    int n;
    int bad;
    n = 0;
    bad = 0;
    bus.start        = 1'b1;
    bus.len          = 6'd20;
    bus.block_sel_in = 2'd1;
    bus.data_ready   = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int c = 0; c < 50 && n < 5; c++) begin
      @(negedge clk);
      if (bus.data_in_valid) n++;
      if (n < 5) begin
        @(posedge clk); #1;
      end
    end
    chk("rst_words", n, 5);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_data", bus.data_in, 0);
    chk("rst_valid", 32'(bus.data_in_valid), 0);
    chk("rst_bsel", bus.block_sel, 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (bus.done || bus.busy) bad++;
    end
    #2 rst_n = 1'b1;
    @(negedge clk);
    if (bus.done || bus.busy) bad++;
    chk("rst_quiet", bad, 0);
    @(posedge clk); #1;
    bus.data_ready = 1'b0;
    run_stream(3, 2'd3, 0, 0, 3);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n            = 1'b0;
    bus.wr_en        = 1'b0;
    bus.wr_addr      = '0;
    bus.wr_data      = '0;
    bus.start        = 1'b0;
    bus.len          = '0;
    bus.block_sel_in = '0;
    bus.data_ready   = 1'b0;
    #1;
    chk("init_data", bus.data_in, 0);
    chk("init_valid", 32'(bus.data_in_valid), 0);
    chk("init_busy", 32'(bus.busy), 0);
    chk("init_done", 32'(bus.done), 0);
    chk("init_bsel", bus.block_sel, 0);
    #12 rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 32; i++)
      write_word(i, 16'(i + 1));

    vecs.push_back('{30, 2'd2, 0, 1'b0, 30});
    vecs.push_back('{4,  2'd1, 1, 1'b0, 4});
    vecs.push_back('{0,  2'd3, 0, 1'b0, 0});
    vecs.push_back('{40, 2'd1, 0, 1'b0, 32});
    vecs.push_back('{32, 2'd3, 2, 1'b0, 32});
    vecs.push_back('{6,  2'd2, 0, 1'b1, 6});
    vecs.push_back('{1,  2'd0, 0, 1'b0, 1});
    vecs.push_back('{2,  2'd1, 1, 1'b0, 2});
    foreach (vecs[i])
      run_stream(vecs[i].ln, vecs[i].bs, vecs[i].mode,
                 vecs[i].poke, vecs[i].exp_n);

    for (int r = 0; r < 8; r++) begin
      int ln;
      int nw;
      nw = $urandom_range(1, 8);
      for (int k = 0; k < nw; k++)
        write_word($urandom_range(0, 31),
                   16'($urandom));
      ln = $urandom_range(0, 40);
      run_stream(ln, 2'($urandom_range(0, 3)), 2, 1'b0,
                 (ln > 32) ? 32 : ln);
    end

    reset_mid_stream();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/token_stream_tx.md
TOKEN_STREAM_TX -- requirements
Module: token_stream_tx

Interface
REQ-001 SHALL have parameter DATA_W, default 16, token word width.
REQ-002 SHALL have parameter DEPTH, default 32, buffer entries.
REQ-003 SHALL have parameter ADDR_W, default 5, buffer address width (log2 DEPTH).
REQ-004 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port wr_en  input  1  buffer write strobe.
REQ-007 SHALL have port wr_addr  input  ADDR_W  buffer write address.
REQ-008 SHALL have port wr_data  input  DATA_W  buffer write data.
REQ-009 SHALL have port start  input  1  begin-stream pulse.
REQ-010 SHALL have port len  input  ADDR_W+1  word count for the stream, sampled at start.
REQ-011 SHALL have port block_sel_in  input  2  block select, sampled at start.
REQ-012 SHALL have port data_ready  input  1  downstream accept.
REQ-013 SHALL have port data_in  output  DATA_W  streamed word, for the QKV data_in port.
REQ-014 SHALL have port data_in_valid  output  1  data_in holds a valid word.
REQ-015 SHALL have port block_sel  output  2  latched block select, held for the whole stream.
REQ-016 SHALL have port busy  output  1  high from the cycle after start is accepted until done.
REQ-017 SHALL have port done  output  1  one-cycle pulse after the last word is accepted.

Function
REQ-018 SHALL use an FSM with states IDLE, LOAD, STREAM, DONE.
REQ-019 In IDLE, the block SHALL write wr_data to buffer[wr_addr] on wr_en; in all other states it SHALL ignore wr_en.
REQ-020 In IDLE, start with len != 0 SHALL latch len (clamped to DEPTH) and block_sel_in, reset the read pointer to 0, and go to LOAD.
REQ-021 start with len == 0, or start outside IDLE, SHALL be ignored: no state change and no done pulse.
REQ-022 LOAD SHALL register buffer[0] into data_in, assert data_in_valid, and go to STREAM; the first valid word therefore appears 2 cycles after start is sampled.
REQ-023 In STREAM, a word SHALL transfer on each edge where data_in_valid && data_ready.
- On transfer, the next word (buffer[ptr+1]) SHALL load into data_in on the same edge.
- At full throughput the stream SHALL deliver one word per cycle.
REQ-024 While data_ready is low, data_in and data_in_valid SHALL hold stable.
REQ-025 When the transfer of word len-1 completes, data_in_valid SHALL drop on the same edge and the FSM SHALL go to DONE.
REQ-026 DONE SHALL assert done for exactly one cycle and then return to IDLE.
REQ-027 busy SHALL be high in the LOAD, STREAM and DONE states.
REQ-028 block_sel SHALL hold its latched value until the next accepted start.
REQ-029 The read pointer SHALL be ADDR_W+1 bits and SHALL NOT wrap; len == DEPTH SHALL read entries 0..DEPTH-1 exactly once.
REQ-030 data_in SHALL retain the last transferred word after the stream ends; data_in_valid qualifies it.

Reset
REQ-031 On rst_n low, asynchronously: state IDLE, data_in 0, data_in_valid 0, block_sel 0, busy 0, done 0, pointer 0, latched len 0.
REQ-032 Buffer contents SHALL NOT be reset and SHALL retain their values across reset.
REQ-033 Reset asserted mid-stream SHALL abort the stream with no done pulse; after release the block SHALL accept a new start normally.

Verification
REQ-034 Basic stream: write 0x0001..0x001E to addresses 0..29, start with len=30, block_sel_in=2, data_ready held 1 -> 30 consecutive valid words 0x0001..0x001E, block_sel=2 throughout, done pulses 1 cycle after the last word.
REQ-035 Backpressure: len=4, data_ready low on every other cycle -> the same 4 words in order, no duplicates or drops, data_in stable while stalled.
REQ-036 Boundaries: len=0 -> no busy, no done; len=40 -> exactly 32 words, entries 0..31.
REQ-037 Write/start interlock: wr_en to address 0 and a second start during STREAM -> both ignored, and the next stream shows the original buffer[0] value.
REQ-038 Reset mid-stream: rst_n low after 5 words -> all outputs 0 asynchronously, no done pulse; a new start with len=3 after release -> buffer[0..2] streamed correctly.
